spi_command_decoder: RTL and testbench

Parametrised SPI command decoder between the SPI slave byte interface and the core's instruction/address/value buses. It frames the multi-byte commands WRITE, READ, BIND_INTERRUPT and BIND_ADDRESS into one-cycle command strobes. It serves TRANSFER and REPEAT by streaming a snapshot of `value_from_core` MSB-first. It adds explicit reset, per-width frame lengths, a strobe/error handshake and an optional inter-byte timeout.

---
 rtl/spi_command_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_spi_command_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_command_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spi_command_decoder
// Purpose  : Frames SPI bytes into command strobes and streams core values.
//            Optional inter-byte timeout enabled by SPI_CMD_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module spi_command_decoder #(
    parameter int INSTRUCTION_WIDTH = 8,
    parameter int ADDRESS_WIDTH     = 24,
    parameter int VALUE_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_rx_valid,
    input  logic [7:0]                   spi_rx_byte,
    input  logic [VALUE_WIDTH-1:0]       value_from_core,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_bus,
    output logic [ADDRESS_WIDTH-1:0]     address_bus,
    output logic [VALUE_WIDTH-1:0]       value_bus,
    output logic                         cmd_valid,
    output logic                         cmd_error,
    output logic                         busy,
    output logic [7:0]                   spi_tx_byte
);

    localparam int ADDR_BYTES = ADDRESS_WIDTH / 8;
    localparam int VAL_BYTES  = VALUE_WIDTH / 8;
    localparam int ARG_WIDTH  = ADDRESS_WIDTH + VALUE_WIDTH;
    localparam int REM_W      = $clog2(ADDR_BYTES + VAL_BYTES + 1);
    localparam int TXP_W      = (VAL_BYTES > 1) ? $clog2(VAL_BYTES) : 1;

    localparam logic [7:0] OP_WRITE          = 8'h01;
    localparam logic [7:0] OP_READ           = 8'h02;
    localparam logic [7:0] OP_BIND_INTERRUPT = 8'h03;
    localparam logic [7:0] OP_BIND_ADDRESS   = 8'h04;
    localparam logic [7:0] OP_TRANSFER       = 8'h05;
    localparam logic [7:0] OP_REPEAT         = 8'h06;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                       state_q,     state_d;
    logic [7:0]                   opcode_q,    opcode_d;
    logic [REM_W-1:0]             remaining_q, remaining_d;
    logic [ARG_WIDTH-1:0]         arg_q,       arg_d;
    logic [INSTRUCTION_WIDTH-1:0] instr_q,     instr_d;
    logic [ADDRESS_WIDTH-1:0]     addr_q,      addr_d;
    logic [VALUE_WIDTH-1:0]       value_q,     value_d;
    logic                         cmd_valid_q, cmd_valid_d;
    logic                         cmd_error_q, cmd_error_d;
    logic [7:0]                   tx_byte_q,   tx_byte_d;
    logic [TXP_W-1:0]             tx_ptr_q,    tx_ptr_d;
    logic [VALUE_WIDTH-1:0]       snap_q,      snap_d;

`ifdef SPI_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]             tmo_q,       tmo_d;
`endif

    logic [ARG_WIDTH-1:0]         w_arg_shift;
    logic [VALUE_WIDTH-1:0]       w_snap_shifted;
    logic                         w_is_frame_op;

    assign w_arg_shift    = {arg_q[ARG_WIDTH-9:0], spi_rx_byte};
    // Shifting the snapshot left brings byte tx_ptr (0 = MSB) to the top.
    assign w_snap_shifted = snap_q << {tx_ptr_q, 3'b000};
    assign w_is_frame_op  = (spi_rx_byte == OP_WRITE) || (spi_rx_byte == OP_READ) ||
                            (spi_rx_byte == OP_BIND_INTERRUPT) ||
                            (spi_rx_byte == OP_BIND_ADDRESS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            opcode_q    <= '0;
            remaining_q <= '0;
            arg_q       <= '0;
            instr_q     <= '0;
            addr_q      <= '0;
            value_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_error_q <= 1'b0;
            tx_byte_q   <= '0;
            tx_ptr_q    <= '0;
            snap_q      <= '0;
`ifdef SPI_CMD_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            remaining_q <= remaining_d;
            arg_q       <= arg_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            value_q     <= value_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_error_q <= cmd_error_d;
            tx_byte_q   <= tx_byte_d;
            tx_ptr_q    <= tx_ptr_d;
            snap_q      <= snap_d;
`ifdef SPI_CMD_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        remaining_d = remaining_q;
        arg_d       = arg_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        value_d     = value_q;
        cmd_valid_d = 1'b0;
        cmd_error_d = 1'b0;
        tx_byte_d   = tx_byte_q;
        tx_ptr_d    = tx_ptr_q;
        snap_d      = snap_q;
`ifdef SPI_CMD_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif

        case (state_q)
            ST_RECV: begin
                if (spi_rx_valid) begin
                    arg_d       = w_arg_shift;
                    remaining_d = remaining_q - 1'b1;
`ifdef SPI_CMD_TIMEOUT_EN
                    tmo_d       = '0;
`endif
                    if (remaining_q == REM_W'(1)) begin
                        state_d     = ST_DONE;
                        cmd_valid_d = 1'b1;
                        instr_d     = INSTRUCTION_WIDTH'(opcode_q);
                        if (opcode_q == OP_WRITE) begin
                            addr_d  = w_arg_shift[ARG_WIDTH-1 -: ADDRESS_WIDTH];
                            value_d = w_arg_shift[VALUE_WIDTH-1:0];
                        end else begin
                            addr_d  = w_arg_shift[ADDRESS_WIDTH-1:0];
                            value_d = '0;
                        end
                    end
                end
`ifdef SPI_CMD_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = ST_IDLE;
                    cmd_error_d = 1'b1;
                    tmo_d       = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end

            // DONE lasts one cycle and accepts a new opcode exactly like IDLE.
            default: begin
                state_d = ST_IDLE;
                if (spi_rx_valid) begin
                    if (w_is_frame_op) begin
                        state_d     = ST_RECV;
                        opcode_d    = spi_rx_byte;
                        arg_d       = '0;
                        remaining_d = (spi_rx_byte == OP_WRITE) ?
                                      REM_W'(ADDR_BYTES + VAL_BYTES) : REM_W'(ADDR_BYTES);
`ifdef SPI_CMD_TIMEOUT_EN
                        tmo_d       = '0;
`endif
                    end else if (spi_rx_byte == OP_TRANSFER) begin
                        if (tx_ptr_q == '0) begin
                            snap_d    = value_from_core;
                            tx_byte_d = value_from_core[VALUE_WIDTH-1 -: 8];
                        end else begin
                            tx_byte_d = w_snap_shifted[VALUE_WIDTH-1 -: 8];
                        end
                        tx_ptr_d = (tx_ptr_q == TXP_W'(VAL_BYTES - 1)) ? '0 : tx_ptr_q + 1'b1;
                    end else if (spi_rx_byte == OP_REPEAT) begin
                        tx_ptr_d = '0;
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                end
            end
        endcase
    end

    assign instruction_bus = instr_q;
    assign address_bus     = addr_q;
    assign value_bus       = value_q;
    assign cmd_valid       = cmd_valid_q;
    assign cmd_error       = cmd_error_q;
    assign busy            = (state_q == ST_RECV);
    assign spi_tx_byte     = tx_byte_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_command_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_command_decoder
// Purpose  : Directed self-checking bench for spi_command_decoder.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_command_decoder;

    localparam logic [7:0] OP_WRITE    = 8'h01;
    localparam logic [7:0] OP_READ     = 8'h02;
    localparam logic [7:0] OP_BIND_INT = 8'h03;
    localparam logic [7:0] OP_BIND_ADR = 8'h04;
    localparam logic [7:0] OP_TRANSFER = 8'h05;
    localparam logic [7:0] OP_REPEAT   = 8'h06;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic [31:0] core_val;
    logic [7:0]  instr;
    logic [23:0] addr;
    logic [31:0] val;
    logic        cmd_valid;
    logic        cmd_error;
    logic        busy;
    logic [7:0]  tx_byte;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int n_busy   = 0;

    always #5 clk = ~clk;

    spi_command_decoder #(
        .INSTRUCTION_WIDTH (8),
        .ADDRESS_WIDTH     (24),
        .VALUE_WIDTH       (32),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi_rx_valid    (rx_valid),
        .spi_rx_byte     (rx_byte),
        .value_from_core (core_val),
        .instruction_bus (instr),
        .address_bus     (addr),
        .value_bus       (val),
        .cmd_valid       (cmd_valid),
        .cmd_error       (cmd_error),
        .busy            (busy),
        .spi_tx_byte     (tx_byte)
    );

    // Pulse counters sample pre-edge values, so each cycle is counted once.
    always @(posedge clk) begin
        if (cmd_valid) n_valid++;
        if (cmd_error) n_err++;
        if (busy)      n_busy++;
    end

    typedef struct {
        string       nm;
        int          n;
        logic [63:0] frame;
        logic [7:0]  ei;
        logic [23:0] ea;
        logic [31:0] ev;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge after the byte was sampled.
    task automatic strobe(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic check_cmd(input string nm, input logic [7:0] ei,
                             input logic [23:0] ea, input logic [31:0] ev);
        chk({nm, "_valid"}, cmd_valid, 1'b1);
        chk({nm, "_instr"}, instr, ei);
        chk({nm, "_addr"},  addr, ea);
        chk({nm, "_value"}, val, ev);
    endtask

    initial begin
        int v0;
        int e0;
        int b0;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        core_val = 32'h0;

        vecs[0] = '{"write_basic", 8, 64'h01_000010_DEADBEEF, OP_WRITE,    24'h000010, 32'hDEADBEEF};
        vecs[1] = '{"read_basic",  4, 64'h02_123456,          OP_READ,     24'h123456, 32'h0};
        vecs[2] = '{"bind_int",    4, 64'h03_ABCDEF,          OP_BIND_INT, 24'hABCDEF, 32'h0};
        vecs[3] = '{"bind_addr",   4, 64'h04_05FF01,          OP_BIND_ADR, 24'h05FF01, 32'h0};
        vecs[4] = '{"write_ones",  8, 64'h01_FFFFFF_00000001, OP_WRITE,    24'hFFFFFF, 32'h00000001};

        repeat (3) @(negedge clk);
        chk("rst_instr", instr, 8'h0);
        chk("rst_addr", addr, 24'h0);
        chk("rst_value", val, 32'h0);
        chk("rst_valid", cmd_valid, 1'b0);
        chk("rst_error", cmd_error, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx", tx_byte, 8'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            v0 = n_valid;
            b0 = n_busy;
            for (int j = 0; j < vecs[i].n; j++) begin
                strobe(vecs[i].frame[8*(vecs[i].n-1-j) +: 8]);
                if (j < vecs[i].n - 1) chk({vecs[i].nm, "_busy_mid"}, busy, 1'b1);
            end
            check_cmd(vecs[i].nm, vecs[i].ei, vecs[i].ea, vecs[i].ev);
            chk({vecs[i].nm, "_busy_done"}, busy, 1'b0);
            @(negedge clk);
            chk({vecs[i].nm, "_valid_drop"}, cmd_valid, 1'b0);
            chk({vecs[i].nm, "_pulses"}, n_valid - v0, 1);
            chk({vecs[i].nm, "_busy_cycles"}, n_busy - b0, vecs[i].n - 1);
        end

        // Snapshot streaming: later core changes must not leak into the stream.
        core_val = 32'h11223344;
        strobe(OP_TRANSFER);
        chk("xfer0", tx_byte, 8'h11);
        core_val = 32'h55667788;
        strobe(OP_TRANSFER);
        chk("xfer1", tx_byte, 8'h22);
        strobe(OP_TRANSFER);
        chk("xfer2", tx_byte, 8'h33);
        strobe(OP_TRANSFER);
        chk("xfer3", tx_byte, 8'h44);
        strobe(OP_TRANSFER);
        chk("xfer_wrap", tx_byte, 8'h55);
        strobe(OP_REPEAT);
        chk("repeat_hold", tx_byte, 8'h55);
        core_val = 32'hAABBCCDD;
        strobe(OP_TRANSFER);
        chk("rep_xfer0", tx_byte, 8'hAA);
        strobe(OP_TRANSFER);
        chk("rep_xfer1", tx_byte, 8'hBB);
        strobe(OP_REPEAT);
        chk("rep_hold2", tx_byte, 8'hBB);
        strobe(OP_TRANSFER);
        chk("rep_fresh", tx_byte, 8'hAA);

        // Unknown opcode.
        v0 = n_valid;
        e0 = n_err;
        strobe(8'hFF);
        chk("unk_error", cmd_error, 1'b1);
        chk("unk_valid", cmd_valid, 1'b0);
        chk("unk_addr_hold", addr, 24'hFFFFFF);
        chk("unk_busy", busy, 1'b0);
        @(negedge clk);
        chk("unk_error_drop", cmd_error, 1'b0);
        chk("unk_err_pulses", n_err - e0, 1);
        chk("unk_no_valid", n_valid - v0, 0);

        // Opcodes arriving in the DONE cycle are not lost.
        v0 = n_valid;
        strobe(OP_READ); strobe(8'h01); strobe(8'h02); strobe(8'h03);
        check_cmd("b2b_first", OP_READ, 24'h010203, 32'h0);
        strobe(OP_READ); strobe(8'h04); strobe(8'h05); strobe(8'h06);
        check_cmd("b2b_second", OP_READ, 24'h040506, 32'h0);
        @(negedge clk);
        chk("b2b_pulses", n_valid - v0, 2);
        strobe(OP_REPEAT);
        core_val = 32'h99887766;
        strobe(OP_READ); strobe(8'h00); strobe(8'h00); strobe(8'h07);
        strobe(OP_TRANSFER);
        chk("done_xfer", tx_byte, 8'h99);
        chk("done_xfer_addr", addr, 24'h000007);

        // Asynchronous reset mid-frame.
        v0 = n_valid;
        strobe(OP_WRITE); strobe(8'h00); strobe(8'h00); strobe(8'h10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_instr", instr, 8'h0);
        chk("mid_rst_addr", addr, 24'h0);
        chk("mid_rst_value", val, 32'h0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_tx", tx_byte, 8'h0);
        chk("mid_rst_error", cmd_error, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_no_valid", n_valid - v0, 0);
        strobe(OP_READ); strobe(8'h12); strobe(8'h34); strobe(8'h56);
        check_cmd("post_rst_read", OP_READ, 24'h123456, 32'h0);
        @(negedge clk);

        // Stalled frame: aborts after the timeout, or waits indefinitely.
        v0 = n_valid;
        e0 = n_err;
        strobe(OP_WRITE); strobe(8'h00); strobe(8'h01);
`ifdef SPI_CMD_TIMEOUT_EN
        repeat (15) @(negedge clk);
        chk("tmo_before_error", cmd_error, 1'b0);
        chk("tmo_before_busy", busy, 1'b1);
        @(negedge clk);
        chk("tmo_error", cmd_error, 1'b1);
        chk("tmo_busy", busy, 1'b0);
        chk("tmo_addr_hold", addr, 24'h123456);
        @(negedge clk);
        chk("tmo_err_pulses", n_err - e0, 1);
        chk("tmo_no_valid", n_valid - v0, 0);
`else
        repeat (40) @(negedge clk);
        chk("stall_busy", busy, 1'b1);
        chk("stall_error", cmd_error, 1'b0);
        strobe(8'h02); strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44);
        check_cmd("stall_write", OP_WRITE, 24'h000102, 32'h11223344);
        @(negedge clk);
        chk("stall_no_err", n_err - e0, 0);
`endif
        strobe(OP_READ); strobe(8'hAB); strobe(8'hCD); strobe(8'h00);
        check_cmd("final_read", OP_READ, 24'hABCD00, 32'h0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
